// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: FSM state encodings and
// the default divider-wait timeout.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    CTRL_RUN = 2'd0,
    CTRL_DIV = 2'd1,
    CTRL_BUS = 2'd2
  } ctrl_state_e;

  // Cycles the sequencer waits for the divider before forcing a release.
  localparam int DIV_TO_DEFAULT = 64;

endpackage : pipe_ctrl_pkg

// File: rtl/pipe_ctrl_sat.sv
// Saturating up-counter: increments when en_i is high, sticks at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: hold by default, step only while enabled and not yet full.
  always_comb begin
    // NOTE: assign every comb output a default first so no path leaves it unassigned (no latch).
    cnt_d = cnt_q;
    if (en_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking (<=) so all flops update together at the edge.
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule : sat_counter

// File: rtl/pipe_ctrl.sv
// Central pipeline sequencer: turns jumps, load-use hazards, divider
// occupancy and bus freeze requests into stall/flush flags for the
// pc_reg -> if_id -> id_ex -> ex pipeline, plus a stall-cycle counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W  = 32,
  parameter int DIV_TO = DIV_TO_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             jump_en_i,
  input  logic [31:0]      jump_addr_i,
  input  logic             load_use_i,
  input  logic             div_start_i,
  input  logic             div_ready_i,
  input  logic             bus_req_i,
  output logic             jump_en_o,
  output logic [31:0]      jump_addr_o,
  output logic             stall_pc_o,
  output logic             stall_if_id_o,
  output logic             flush_if_id_o,
  output logic             flush_id_ex_o,
  output logic             bus_gnt_o,
  output logic             div_err_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam int TMO_W = (DIV_TO > 1) ? $clog2(DIV_TO) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(DIV_TO - 1);

  ctrl_state_e      state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             bus_gnt_q, bus_gnt_d;

  // Next state, timeout count and same-cycle pipeline control flags.
  always_comb begin
    state_d       = state_q;
    tmo_d         = tmo_q;
    jump_en_o     = 1'b0;
    jump_addr_o   = '0;
    stall_pc_o    = 1'b0;
    stall_if_id_o = 1'b0;
    flush_if_id_o = 1'b0;
    flush_id_ex_o = 1'b0;
    div_err_o     = 1'b0;

    // Flags stay quiet while reset is held, even though inputs may be active.
    if (rst_n) begin
      unique case (state_q)
        CTRL_RUN: begin
          if (jump_en_i) begin
            // The hazarding instruction is flushed, so hazards/bus are moot.
            jump_en_o     = 1'b1;
            jump_addr_o   = jump_addr_i;
            flush_if_id_o = 1'b1;
            flush_id_ex_o = 1'b1;
          end else if (div_start_i) begin
            stall_pc_o    = 1'b1;
            stall_if_id_o = 1'b1;
            flush_id_ex_o = 1'b1;
            state_d       = CTRL_DIV;
            tmo_d         = '0;
          end else if (load_use_i) begin
            stall_pc_o    = 1'b1;
            stall_if_id_o = 1'b1;
            flush_id_ex_o = 1'b1;
          end else if (bus_req_i) begin
            // Drain this cycle; grant appears once the pipeline is empty.
            stall_pc_o    = 1'b1;
            stall_if_id_o = 1'b1;
            flush_id_ex_o = 1'b1;
            state_d       = CTRL_BUS;
          end
        end

        CTRL_DIV: begin
          stall_pc_o    = 1'b1;
          stall_if_id_o = 1'b1;
          flush_id_ex_o = 1'b1;
          tmo_d         = tmo_q + 1'b1;
          if (div_ready_i) begin
            state_d = CTRL_RUN;
          end else if (tmo_q == TMO_LAST) begin
            div_err_o = 1'b1;
            state_d   = CTRL_RUN;
          end
        end

        CTRL_BUS: begin
          stall_pc_o    = 1'b1;
          stall_if_id_o = 1'b1;
          flush_id_ex_o = 1'b1;
          if (!bus_req_i) state_d = CTRL_RUN;
        end

        default: state_d = CTRL_RUN;
      endcase
    end

    bus_gnt_d = (state_d == CTRL_BUS);
  end

  // State, timeout and grant registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CTRL_RUN;
      tmo_q     <= '0;
      bus_gnt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      bus_gnt_q <= bus_gnt_d;
    end
  end

  assign bus_gnt_o = bus_gnt_q;

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (stall_pc_o),
    .cnt_o (stall_cnt_o)
  );

endmodule : pipe_ctrl

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline sequencer for the 3-stage core (pc_reg -> if_id -> id_ex -> ex). Combines ex-stage jumps, id-stage load-use hazards, multi-cycle divider occupancy and external bus-master freeze requests. From these it generates the stall and flush flags consumed by pc_reg and the pipeline registers. A flush makes a pipeline register load its default value; for id_ex that is INST_NOP with reg_wen=0. The block also keeps a saturating stall-cycle counter for performance monitoring.

Parameters:
CNT_W, 32, width of the stall-cycle counter
DIV_TO, 64, divider-wait timeout in cycles; if reached, the divider is forced released and div_err_o pulses

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
jump_en_i  in  1  ex: branch/jump taken this cycle
jump_addr_i  in  32  ex: jump target
load_use_i  in  1  id: source register depends on the load now in ex
div_start_i  in  1  ex: divide issued this cycle
div_ready_i  in  1  divider: result written back this cycle
bus_req_i  in  1  external master requests pipeline freeze (level)
jump_en_o  out  1  to pc_reg: load jump_addr_o
jump_addr_o  out  32  to pc_reg
stall_pc_o  out  1  pc_reg keeps its current value
stall_if_id_o  out  1  if_id keeps its contents
flush_if_id_o  out  1  if_id loads its default (NOP)
flush_id_ex_o  out  1  id_ex loads its default (NOP, reg_wen=0)
bus_gnt_o  out  1  registered grant to the external master
div_err_o  out  1  one-cycle pulse on divider timeout
stall_cnt_o  out  CNT_W  saturating count of cycles with stall_pc_o=1

Behaviour:
- Interface: one clock, clk. Reset is rst_n, asynchronous and active-low.
- Reset values:
  - state=RUN.
  - All flag outputs, bus_gnt_o and div_err_o are 0.
  - jump_addr_o=0, stall_cnt_o=0, timeout counter=0.
- FSM states: RUN, DIV_WAIT, BUS_WAIT.
- RUN, outputs are combinational and take effect in the same cycle. Priority order:
  1. jump_en_i:
     - jump_en_o=1, jump_addr_o=jump_addr_i.
     - flush_if_id_o=1 and flush_id_ex_o=1.
     - load_use_i and bus_req_i are ignored this cycle, because the hazarding instruction is flushed.
  2. div_start_i:
     - stall_pc_o=1, stall_if_id_o=1, flush_id_ex_o=1.
     - Next state is DIV_WAIT; the timeout counter clears to 0.
  3. load_use_i:
     - stall_pc_o=1, stall_if_id_o=1, flush_id_ex_o=1 for exactly this cycle.
     - Stay in RUN.
  4. bus_req_i:
     - stall_pc_o=1, stall_if_id_o=1, flush_id_ex_o=1.
     - Next state is BUS_WAIT. bus_gnt_o rises on the following clock edge, when the pipeline is drained.
- DIV_WAIT:
  - stall_pc_o, stall_if_id_o and flush_id_ex_o are all 1.
  - The timeout counter increments each cycle.
  - If div_ready_i=1, go to RUN; normal issue resumes next cycle.
  - Else, if the counter reaches DIV_TO-1, pulse div_err_o for one cycle and go to RUN.
  - jump_en_i, load_use_i and bus_req_i are ignored; ex holds only a bubble.
  - div_ready_i and the timeout in the same cycle: ready wins and there is no error.
- BUS_WAIT:
  - bus_gnt_o=1 (registered); stall_pc_o, stall_if_id_o and flush_id_ex_o are all 1.
  - When bus_req_i drops: bus_gnt_o=0 on the next edge and state goes to RUN.
  - Minimum grant length is one cycle.
- div_start_i and bus_req_i together in RUN: the divider wins. The bus request stays pending and is granted once the divider returns to RUN.
- stall_cnt_o increments on every edge where stall_pc_o=1 and saturates at all-ones (no wrap).
- flush_if_id_o is asserted only on a jump. When stall_if_id_o and flush_if_id_o would both be 1, flush takes precedence; by construction this cannot happen.
- Reset mid-DIV_WAIT or mid-BUS_WAIT returns immediately to RUN and bus_gnt_o drops asynchronously.

Decomposition:
- Shared defines file gets:
  - state encodings CTRL_RUN=2'd0, CTRL_DIV=2'd1, CTRL_BUS=2'd2;
  - the default DIV_TO value.
- INST_NOP stays where it is already defined.
- Sub-module: sat_counter (parameterised width, enable, saturate), used for stall_cnt_o. The FSM and the timeout counter stay inline.

Test Plan:
- Reset check: hold rst_n=0 mid-sim with bus_req_i=1 -> bus_gnt_o=0 immediately, all flags 0, stall_cnt_o=0, state RUN after release.
- Jump in RUN: jump_en_i=1, jump_addr_i=0x0000_0040 for one cycle -> same cycle jump_en_o=1, jump_addr_o=0x40, both flushes 1, stalls 0, stall_cnt_o unchanged.
- Load-use: load_use_i=1 for one cycle -> exactly 1 cycle of stall_pc_o, stall_if_id_o and flush_id_ex_o; stall_cnt_o +1.
- Divider: div_start_i pulse, then div_ready_i after 10 cycles -> stalls held 11 cycles, RUN on the next edge, stall_cnt_o=11. Second run with no div_ready_i -> div_err_o pulses at cycle DIV_TO, then RUN.
- Bus freeze: bus_req_i high for 5 cycles -> bus_gnt_o rises one edge after the request, stays high until one edge after the drop. Repeat with div_start_i in the same cycle -> grant only after DIV_WAIT exits.
- Saturation: CNT_W=4, stall for 20 cycles -> stall_cnt_o=15 and holds.
